sig_capture_peri: RTL



---
 rtl/sig_capture_pkg.sv | 25 ++
 rtl/sig_fifo.sv | 54 +++++
 rtl/sig_capture_peri.sv | 109 ++++++++++
 3 files changed

// File: rtl/sig_capture_pkg.sv
// Shared types and default addresses for the compliance signature-capture peripheral.
package sig_capture_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [31:0] SIG_ADDR_DEF  = 32'h8E00_0000;
    localparam logic [31:0] HALT_ADDR_DEF = 32'h8F00_0000;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    // Status readback has a 5-bit count field; deeper FIFOs pin it at 31.
    function automatic logic [4:0] sat_count5(input logic [31:0] c);
        return (c > 32'd31) ? 5'd31 : c[4:0];
    endfunction

endpackage

// File: rtl/sig_fifo.sv
// Synchronous FIFO with occupancy count; the head word reads as zero when empty.
module sig_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sig_capture_peri.sv
// Bus-attached signature capture: queues signature writes, streams them out,
// and flags halt once a halt request has been seen and the queue has drained.
module sig_capture_peri
    import sig_capture_pkg::*;
#(
    parameter logic [31:0] SIG_ADDR   = SIG_ADDR_DEF,
    parameter logic [31:0] HALT_ADDR  = HALT_ADDR_DEF,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        sig_valid_o,
    output logic [31:0] sig_data_o,
    input  logic        sig_ready_i,
    output logic        halt_o,
    output logic        err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    bus_req_t    req;
    state_e      state_q, state_d;
    logic        is_sig, is_halt, in_run;
    logic        accept, wr_acc, push, pop;
    logic        full, empty;
    logic [AW:0] count;
    logic        ack_q, err_q;
    logic [31:0] rdata_q;

    assign req = '{valid: req_valid_i, we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};

    assign is_sig  = (req.addr == SIG_ADDR);
    assign is_halt = (req.addr == HALT_ADDR);
    assign in_run  = (state_q == RUN);

    // Only a signature write that would overflow the queue is back-pressured.
    assign req_ready_o = ~(req.we & is_sig & full & in_run);
    assign accept      = req.valid & req_ready_o;
    assign wr_acc      = accept & req.we;
    assign push        = wr_acc & is_sig & in_run;
    assign pop         = sig_valid_o & sig_ready_i;

    sig_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (req.wdata),
        .pop   (pop),
        .rdata (sig_data_o),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign sig_valid_o = ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (wr_acc & is_halt) state_d = DRAIN;
            DRAIN:   if (empty) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Any write after the halt request indicates a misbehaving test program.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (wr_acc & ~in_run)
            err_q <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= accept;
            if (accept & ~req.we)
                rdata_q <= {state_q, 25'b0, sat_count5(32'(count))};
            else
                rdata_q <= '0;
        end
    end

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign halt_o  = (state_q == HALTED);
    assign err_o   = err_q;

endmodule
